// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM-stage load/store port.
// One request per handshake, fixed-latency access on a word array.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_datatype,
  input  logic        req_signed,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } state_t;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic        r_write;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [1:0]  r_dt;
  logic        r_signed;

  logic [31:0] mem [DEPTH];

  logic [AW-1:0] idx;
  logic [31:0]   rword;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [31:0]   ldata;
  logic [31:0]   wlane;
  logic [3:0]    be;
  logic          err;
  logic          fire;
  logic          accept;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == RESP);
  assign accept     = req_ready & req_valid;
  assign fire       = (state == BUSY) && (cnt == 4'd0);

  assign idx   = r_addr[AW+1:2];
  assign rword = mem[idx];
  assign rbyte = rword[{r_addr[1:0], 3'b000} +: 8];
  assign rhalf = r_addr[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    err   = 1'b0;
    be    = 4'h0;
    wlane = r_wdata;
    ldata = '0;
    unique case (r_dt)
      2'd0: begin
        err   = |r_addr[1:0];
        be    = 4'hf;
        ldata = rword;
      end
      2'd1: begin
        err   = r_addr[0];
        be    = r_addr[1] ? 4'hc : 4'h3;
        wlane = {2{r_wdata[15:0]}};
        ldata = {{16{r_signed & rhalf[15]}}, rhalf};
      end
      2'd2: begin
        be    = 4'b0001 << r_addr[1:0];
        wlane = {4{r_wdata[7:0]}};
        ldata = {{24{r_signed & rbyte[7]}}, rbyte};
      end
      default: err = 1'b1;
    endcase
    // Anything above the array's byte span is out of range.
    if (r_addr[31:AW+2] != '0)
      err = 1'b1;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    unique case (state)
      IDLE: begin
        if (req_valid) begin
          state_nxt = BUSY;
          cnt_nxt   = 4'(LATENCY - 1);
        end
      end
      BUSY: begin
        if (cnt == 4'd0)
          state_nxt = RESP;
        else
          cnt_nxt = cnt - 4'd1;
      end
      RESP: begin
        if (resp_ready)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      r_write    <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_dt       <= 2'd0;
      r_signed   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (accept) begin
        r_write  <= req_write;
        r_addr   <= req_addr;
        r_wdata  <= req_wdata;
        r_dt     <= req_datatype;
        r_signed <= req_signed;
      end
      if (fire) begin
        resp_rdata <= (r_write | err) ? '0 : ldata;
        resp_err   <= err;
      end
    end
  end

  // Array is never reset; the commit is gated by the reset-cleared FSM.
  always_ff @(posedge clk) begin
    if (fire && r_write && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (be[k])
          mem[idx][8*k +: 8] <= wlane[8*k +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: byte-array reference model, per-cycle
// output compare, directed corner cases and randomized traffic.
module tb_dmem_responder;

  localparam int DEPTH = 64;
  localparam int LAT   = 2;
  localparam int NB    = DEPTH * 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write, req_signed;
  logic [31:0] req_addr, req_wdata;
  logic [1:0]  req_datatype;
  logic        resp_valid, resp_ready, resp_err;
  logic [31:0] resp_rdata;

  logic        req_valid1, req_ready1, req_write1, req_signed1;
  logic [31:0] req_addr1, req_wdata1;
  logic [1:0]  req_datatype1;
  logic        resp_valid1, resp_ready1, resp_err1;
  logic [31:0] resp_rdata1;

  always #5 clk = ~clk;

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_datatype(req_datatype),
    .req_signed(req_signed),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dmem_responder #(.DEPTH(16), .LATENCY(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .req_datatype(req_datatype1),
    .req_signed(req_signed1),
    .resp_valid(resp_valid1), .resp_ready(resp_ready1),
    .resp_rdata(resp_rdata1), .resp_err(resp_err1)
  );

  logic [7:0]  mb [NB];
  int          n_vec = 0;
  int          n_bad = 0;
  logic        checking = 1'b0;
  logic        exp_ready, exp_valid, exp_err;
  logic [31:0] exp_rdata;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference: byte-addressed array, size in bytes, arithmetic extension.
  function automatic void model_eval(
    input logic w, input logic [31:0] a, input logic [31:0] d,
    input logic [1:0] dt, input logic s,
    output logic [31:0] rd, output logic e);
    int n;
    logic [31:0] v;
    n  = (dt == 2'd0) ? 4 : (dt == 2'd1) ? 2 : 1;
    e  = (dt == 2'd3) || ((a % n) != 0) || (a >= 32'(NB));
    rd = '0;
    if (!e) begin
      if (w) begin
        for (int i = 0; i < n; i++) mb[int'(a) + i] = d[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < n; i++)
          v = v | (32'(mb[int'(a) + i]) << (8 * i));
        if (s && n < 4 && v[8*n-1])
          v = v | (32'hFFFF_FFFF << (8 * n));
        rd = v;
      end
    end
  endfunction

  always @(negedge clk) begin
    if (checking && !rst) begin
      chk("req_ready", 32'(req_ready), 32'(exp_ready));
      chk("resp_valid", 32'(resp_valid), 32'(exp_valid));
      chk("resp_rdata", resp_rdata, exp_rdata);
      chk("resp_err", 32'(resp_err), 32'(exp_err));
    end
  end

  task automatic junk_req();
    req_valid    = 1'($urandom);
    req_write    = 1'($urandom);
    req_addr     = $urandom;
    req_wdata    = $urandom;
    req_datatype = 2'($urandom);
    req_signed   = 1'($urandom);
  endtask

  task automatic access(input logic w, input logic [31:0] a,
                        input logic [31:0] d, input logic [1:0] dt,
                        input logic s, input int stall,
                        output logic [31:0] got_rd, output logic got_err);
    logic [31:0] rd;
    logic        e;
    req_write = w; req_addr = a; req_wdata = d;
    req_datatype = dt; req_signed = s; req_valid = 1'b1;
    @(posedge clk); #1;
    exp_ready  = 1'b0;
    junk_req();
    resp_ready = 1'($urandom);
    repeat (LAT) begin
      @(posedge clk); #1;
      junk_req();
    end
    model_eval(w, a, d, dt, s, rd, e);
    exp_valid  = 1'b1;
    exp_rdata  = rd;
    exp_err    = e;
    got_rd     = resp_rdata;
    got_err    = resp_err;
    resp_ready = (stall == 0);
    repeat (stall) begin
      @(posedge clk); #1;
      junk_req();
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    exp_valid  = 1'b0;
    exp_ready  = 1'b1;
    req_valid  = 1'b0;
    resp_ready = 1'($urandom);
  endtask

  // Store word at 0x40, then reset while BUSY (in_resp=0) or RESP (1).
  task automatic reset_during(input logic in_resp, input logic [31:0] d);
    logic [31:0] rd;
    logic        e;
    req_write = 1'b1; req_addr = 32'h40; req_wdata = d;
    req_datatype = 2'd0; req_signed = 1'b0; req_valid = 1'b1;
    @(posedge clk); #1;
    exp_ready = 1'b0;
    req_valid = 1'b0;
    resp_ready = 1'b0;
    if (in_resp) begin
      repeat (LAT) @(posedge clk);
      #1;
      model_eval(1'b1, 32'h40, d, 2'd0, 1'b0, rd, e);
      exp_valid = 1'b1; exp_rdata = rd; exp_err = e;
      @(posedge clk); #1;
    end
    rst = 1'b1;
    #1;
    chk("rst_async_ready", 32'(req_ready), 32'd1);
    chk("rst_async_valid", 32'(resp_valid), 32'd0);
    chk("rst_async_rdata", resp_rdata, 32'd0);
    chk("rst_async_err", 32'(resp_err), 32'd0);
    exp_ready = 1'b1; exp_valid = 1'b0;
    exp_rdata = '0;   exp_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd, prior;
    logic        e;
    int          k;
    logic [31:0] a;
    logic [1:0]  dt;

    rst = 1'b1;
    req_valid = 0; req_write = 0; req_addr = 0; req_wdata = 0;
    req_datatype = 0; req_signed = 0; resp_ready = 0;
    req_valid1 = 0; req_write1 = 0; req_addr1 = 0; req_wdata1 = 0;
    req_datatype1 = 0; req_signed1 = 0; resp_ready1 = 0;
    exp_ready = 1'b1; exp_valid = 1'b0; exp_rdata = '0; exp_err = 1'b0;
    #2;
    chk("reset_ready", 32'(req_ready), 32'd1);
    chk("reset_valid", 32'(resp_valid), 32'd0);
    chk("reset_rdata", resp_rdata, 32'd0);
    chk("reset_err", 32'(resp_err), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checking = 1'b1;

    for (int i = 0; i < DEPTH; i++)
      access(1'b1, 32'(i * 4), $urandom, 2'd0, 1'b0, 0, rd, e);

    access(1'b1, 32'h10, 32'hDEADBEEF, 2'd0, 1'b0, 0, rd, e);
    chk("st_word_rdata", rd, 32'd0);
    access(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 0, rd, e);
    chk("ld_word", rd, 32'hDEADBEEF);
    chk("ld_word_err", 32'(e), 32'd0);

    access(1'b1, 32'h10, 32'h11223344, 2'd0, 1'b0, 0, rd, e);
    access(1'b1, 32'h13, 32'h00000080, 2'd2, 1'b0, 1, rd, e);
    access(1'b0, 32'h13, 32'h0, 2'd2, 1'b1, 0, rd, e);
    chk("ld_byte_s", rd, 32'hFFFFFF80);
    access(1'b0, 32'h13, 32'h0, 2'd2, 1'b0, 0, rd, e);
    chk("ld_byte_u", rd, 32'h00000080);
    access(1'b0, 32'h10, 32'h0, 2'd0, 1'b0, 0, rd, e);
    chk("ld_word_merge", rd, 32'h80223344);

    access(1'b1, 32'h22, 32'h0000ABCD, 2'd1, 1'b0, 0, rd, e);
    access(1'b0, 32'h22, 32'h0, 2'd1, 1'b1, 0, rd, e);
    chk("ld_half_s", rd, 32'hFFFFABCD);
    access(1'b0, 32'h21, 32'h0, 2'd1, 1'b1, 0, rd, e);
    chk("ld_half_mis_err", 32'(e), 32'd1);
    chk("ld_half_mis_rdata", rd, 32'd0);
    access(1'b1, 32'h22, 32'h12345678, 2'd0, 1'b0, 0, rd, e);
    chk("st_word_mis_err", 32'(e), 32'd1);
    access(1'b0, 32'h20, 32'h0, 2'd0, 1'b0, 5, rd, e);
    chk("word20_unchanged", {16'd0, rd[31:16]}, 32'h0000ABCD);

    access(1'b0, 32'(NB), 32'h0, 2'd0, 1'b0, 0, rd, e);
    chk("oob_err", 32'(e), 32'd1);
    access(1'b0, 32'h8000_0010, 32'h0, 2'd0, 1'b0, 0, rd, e);
    chk("oob_hi_err", 32'(e), 32'd1);
    access(1'b0, 32'h14, 32'h0, 2'd3, 1'b0, 0, rd, e);
    chk("dt3_err", 32'(e), 32'd1);

    access(1'b1, 32'h40, 32'hA5A5_1234, 2'd0, 1'b0, 0, rd, e);
    reset_during(1'b0, 32'h0000_0055);
    access(1'b0, 32'h40, 32'h0, 2'd0, 1'b0, 0, rd, e);
    chk("rst_busy_no_commit", rd, 32'hA5A5_1234);
    reset_during(1'b1, 32'h0000_0055);
    access(1'b0, 32'h40, 32'h0, 2'd0, 1'b0, 0, rd, e);
    chk("rst_resp_committed", rd, 32'h0000_0055);

    for (int i = 0; i < 300; i++) begin
      k  = $urandom_range(0, 15);
      dt = (k == 0) ? 2'd3 : 2'(k % 3);
      if ($urandom_range(0, 15) == 0)
        a = $urandom;
      else
        a = 32'($urandom_range(0, NB - 1));
      if ($urandom_range(0, 1) == 1)
        a = (dt == 2'd0) ? (a & ~32'd3) : (dt == 2'd1) ? (a & ~32'd1) : a;
      access(1'($urandom), a, $urandom, dt, 1'($urandom),
             $urandom_range(0, 3), rd, e);
    end

    checking = 1'b0;
    @(posedge clk); #1;
    req_write1 = 1'b1; req_addr1 = 32'h4; req_wdata1 = 32'hCAFEF00D;
    req_datatype1 = 2'd0; req_signed1 = 1'b0; resp_ready1 = 1'b1;
    req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    chk("l1_busy_ready", 32'(req_ready1), 32'd0);
    chk("l1_busy_valid", 32'(resp_valid1), 32'd0);
    @(posedge clk); #1;
    chk("l1_st_valid", 32'(resp_valid1), 32'd1);
    chk("l1_st_err", 32'(resp_err1), 32'd0);
    @(posedge clk); #1;
    chk("l1_idle_valid", 32'(resp_valid1), 32'd0);
    chk("l1_idle_ready", 32'(req_ready1), 32'd1);
    req_write1 = 1'b0; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    @(posedge clk); #1;
    chk("l1_ld_valid", 32'(resp_valid1), 32'd1);
    chk("l1_ld_rdata", resp_rdata1, 32'hCAFEF00D);
    @(posedge clk); #1;

    prior = 32'd0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory side of the pipeline's MEM-stage load/store interface.
- Accepts one word, halfword or byte request per handshake and performs the access on an internal word array after a programmable latency.
- Returns load data, or a write acknowledge, through a valid/ready response channel.
- The MEM stage stalls on req_ready / resp_valid.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- LATENCY, 2, cycles from request accept to response valid (allowed range 1..15).

Ports:
- Clk  input  1  clock; all logic on the rising edge.
- Rst  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present.
- req_ready  output  1  responder can accept a request.
- req_write  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- req_datatype  input  2  access size: 0 = word, 1 = halfword, 2 = byte, 3 = reserved.
- req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
- resp_valid  output  1  response present.
- resp_ready  input  1  consumer takes the response.
- resp_rdata  output  32  load result, extended to 32 bits; 0 for stores and errors.
- resp_err  output  1  access was misaligned, out of range or reserved-size.

Behaviour:
- Reset (async, Rst=1):
  - state=IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, latency counter=0.
  - Array contents are not cleared.
- FSM states: IDLE, BUSY, RESP.
- IDLE:
  - req_ready=1.
  - When req_valid=1, capture addr, wdata, datatype, signed and write into request registers.
  - Load counter with LATENCY-1 and go to BUSY. req_ready drops in the next cycle.
- BUSY:
  - req_ready=0; counter decrements each cycle.
  - When counter==0: perform the access, register resp_rdata/resp_err, set resp_valid=1, go to RESP.
  - Result: resp_valid rises exactly LATENCY cycles after the accept edge. LATENCY=1 means valid on the edge after accept.
- RESP:
  - resp_valid=1, with resp_rdata and resp_err held stable until resp_ready=1.
  - On a cycle with resp_valid & resp_ready: next state IDLE, resp_valid=0, resp_rdata/resp_err hold their last value.
  - resp_ready=0 stalls indefinitely with no data change.
  - No new request is accepted in RESP. Back-to-back throughput is one access per LATENCY+1 cycles at best.
- Word index = addr[log2(DEPTH)+1 : 2]. Byte lanes are little-endian: lane k (addr[1:0]=k) is bits [8k+7:8k].
- Error conditions (any one sets resp_err=1; no array write; resp_rdata=0):
  - datatype=3;
  - halfword with addr[0]=1;
  - word with addr[1:0]≠0;
  - addr[31 : log2(DEPTH)+2] ≠ 0 (out of range).
- Store:
  - word writes all 4 lanes;
  - halfword writes lanes {addr[1],0} and {addr[1],1} from wdata[15:0];
  - byte writes lane addr[1:0] from wdata[7:0];
  - other lanes are untouched.
  - The write happens on the BUSY→RESP edge. The response then has resp_rdata=0, resp_err=0.
- Load:
  - word returns the full word;
  - halfword/byte extracts the lane(s), then sign-extends if req_signed=1, else zero-extends.
- Request inputs are sampled only at accept; changes during BUSY/RESP are ignored.
- Reset mid-operation (BUSY or RESP):
  - outputs return to reset values immediately and the pending response is discarded;
  - an uncommitted store never reaches the array; a store already committed (RESP) stays.
- req_valid=1 together with reset release: not accepted until the first rising edge with Rst=0.

Test Plan:
- LATENCY=2: store word 0xDEADBEEF @0x10, then load word @0x10 → req_ready low 3 cycles per access; resp_valid rises 2 cycles after each accept; load resp_rdata=0xDEADBEEF, resp_err=0.
- Store byte 0x80 @0x13 over word 0x11223344 @0x10: signed byte load @0x13 → 0xFFFFFF80; unsigned → 0x00000080; word load @0x10 → 0x80223344.
- Halfword store 0xABCD @0x22, signed halfword load @0x22 → 0xFFFFABCD; halfword load @0x21 → resp_err=1, rdata=0; word store @0x22 → resp_err=1 and word @0x20 unchanged.
- resp_ready held 0 for 5 cycles after resp_valid → resp_valid/rdata stable, req_ready=0, a new req_valid is ignored; resp_ready=1 → IDLE next cycle, then the new request is accepted.
- Out-of-range load @ DEPTH*4 and datatype=3 → resp_err=1; LATENCY=1 build → resp_valid on the edge after accept.
- Assert Rst during BUSY of a store 0x55 @0x40 → outputs reset at once (async), req_ready=1; later word load @0x40 returns the prior contents.
